// File: rtl/conv_pkg.sv
// conv_pkg
// Shared types and constants for the 4-tap convolution datapath.
//   WIDTH         - sample / kernel element width
//   LEN           - number of taps (window depth)
//   data_t        - one sample or kernel element
//   result_t      - full-width product / accumulated result
//   data_vector   - kernel bundle, data[i] = k[i]
//   sched_state_t - conv_sched controller states
//   cnt_t         - tap counter, wide enough to index LEN taps
package conv_pkg;

    localparam int WIDTH = 64;
    localparam int LEN   = 4;
    localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;

    typedef logic [WIDTH-1:0]   data_t;
    typedef logic [2*WIDTH-1:0] result_t;

    typedef struct packed {
        data_t [LEN-1:0] data;
    } data_vector;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        OUT
    } sched_state_t;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t LAST_TAP = cnt_t'(LEN - 1);

endpackage

// File: rtl/conv_mac.sv
// conv_mac
// Single shared multiply-accumulate unit: acc <= acc + a*b when en is high.
// Ports:
//   clk - clock
//   a   - sample operand
//   b   - kernel operand
//   clr - synchronous clear of the accumulator (wins over en)
//   en  - accumulate the current product this cycle
//   acc - accumulator register (wraps modulo 2^(2*WIDTH))
module conv_mac
    import conv_pkg::*;
(
    input  logic    clk,
    input  data_t   a,
    input  data_t   b,
    input  logic    clr,
    input  logic    en,
    output result_t acc
);

    result_t product;

    assign product = result_t'(a) * result_t'(b);

    // Accumulator; the sum simply wraps, no saturation.
    always_ff @(posedge clk) begin
        if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + product;
        end
    end

endmodule

// File: rtl/conv_sched.sv
// conv_sched
// Sequencing controller for the convolution datapath. Keeps a kernel and a
// sliding window of the LEN newest samples; for every accepted sample it runs
// the shared MAC over the LEN taps, one tap per cycle, and presents the sum.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   kernel_valid/kernel_ready - kernel load handshake, kernel.data[i] = k[i]
//   in_valid/in_ready/in_data - sample stream
//   out_valid/out_ready       - result handshake
//   out_data                  - sum over i of w[i]*k[i], w[0] newest
//   busy                      - controller is not IDLE
module conv_sched
    import conv_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       kernel_valid,
    output logic       kernel_ready,
    input  data_vector kernel,
    input  logic       in_valid,
    output logic       in_ready,
    input  data_t      in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output result_t    out_data,
    output logic       busy
);

    sched_state_t state;
    cnt_t         cnt;
    data_t        window [LEN];
    data_vector   kern_reg;
    logic         accept_in;
    result_t      mac_acc;

    // Kernel loads take priority over samples while idle.
    assign kernel_ready = (state == IDLE);
    assign in_ready     = (state == IDLE) && !kernel_valid;
    assign busy         = (state != IDLE);
    assign accept_in    = (state == IDLE) && in_valid && !kernel_valid;

    // The accumulator is cleared as the sample is accepted, so after the last
    // CALC cycle it holds the finished sum and stays put (en low) through OUT.
    // It therefore serves directly as the registered result.
    conv_mac u_mac (
        .clk (clk),
        .a   (window[cnt]),
        .b   (kern_reg.data[cnt]),
        .clr (rst || accept_in),
        .en  (state == CALC),
        .acc (mac_acc)
    );

    assign out_data = mac_acc;

    // Controller: window/kernel storage, tap counter and result handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            kern_reg  <= '0;
            out_valid <= 1'b0;
            for (int i = 0; i < LEN; i++) begin
                window[i] <= '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (kernel_valid) begin
                        kern_reg <= kernel;
                    end else if (in_valid) begin
                        for (int i = LEN - 1; i > 0; i--) begin
                            window[i] <= window[i-1];
                        end
                        window[0] <= in_data;
                        cnt       <= '0;
                        state     <= CALC;
                    end
                end
                CALC: begin
                    if (cnt == LAST_TAP) begin
                        cnt       <= '0;
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end else begin
                        cnt <= cnt + cnt_t'(1);
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
